// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state codes, ACK levels and default device address for the I2C EEPROM slave
`timescale 1ns/1ps
package i2c_pkg;
   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1010000;

   // ACK/NACK are SDA bit levels on the wire
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_DEV_ADDR = 4'd1;
   localparam logic [3:0] ST_ACK_DEV  = 4'd2;
   localparam logic [3:0] ST_ADDR_HI  = 4'd3;
   localparam logic [3:0] ST_ACK_HI   = 4'd4;
   localparam logic [3:0] ST_ADDR_LO  = 4'd5;
   localparam logic [3:0] ST_ACK_LO   = 4'd6;
   localparam logic [3:0] ST_WR_DATA  = 4'd7;
   localparam logic [3:0] ST_ACK_WR   = 4'd8;
   localparam logic [3:0] ST_RD_DATA  = 4'd9;
   localparam logic [3:0] ST_RD_ACK   = 4'd10;
   localparam logic [3:0] ST_IGNORE   = 4'd11;
endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - SCL/SDA synchronizers with START/STOP and SCL edge detection
`timescale 1ns/1ps
module i2c_bus_monitor (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_d;
   logic       sda_d;
   logic       scl_s;

   // Reset to the idle bus level so leaving reset never fakes a START
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_eeprom_slave.sv
// rtl/i2c_eeprom_slave.sv - I2C EEPROM-style slave: 2-byte address pointer, sequential write/read of a byte array
`timescale 1ns/1ps
module i2c_eeprom_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR    = DEFAULT_SLAVE_ADDR,
   parameter int         MEM_ADDR_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     scl_in,
   input  logic                     sda_in,
   output logic                     sda_oe,
   output logic                     wr_en,
   output logic [MEM_ADDR_BITS-1:0] wr_addr,
   output logic [7:0]               wr_data,
   output logic                     busy
);
   localparam int DEPTH = 2 ** MEM_ADDR_BITS;
   localparam logic [MEM_ADDR_BITS-1:0] PTR_INC = {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};

   logic                     scl_rise;
   logic                     scl_fall;
   logic                     start_det;
   logic                     stop_det;
   logic                     sda_s;
   logic [3:0]               state;
   logic [3:0]               bit_cnt;
   logic [7:0]               shreg;
   logic [6:0]               tx;
   logic [7:0]               addr_hi;
   logic                     rw;
   logic [MEM_ADDR_BITS-1:0] ptr;
   logic [7:0]               mem [DEPTH];
   logic [7:0]               rd_byte;
   logic                     byte_done;
   logic                     mem_we;

   i2c_bus_monitor u_mon (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   assign byte_done = scl_fall && (bit_cnt == 4'd8);
   assign mem_we    = byte_done && (state == ST_WR_DATA);
   assign rd_byte   = mem[ptr];

   always_ff @(posedge clk) begin
      if (mem_we) mem[ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         tx      <= '0;
         addr_hi <= '0;
         rw      <= 1'b0;
         ptr     <= '0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= 1'b0;
         if (start_det) begin
            state   <= ST_DEV_ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
         end else if (stop_det) begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               ST_DEV_ADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (byte_done) begin
                     case (state)
                        ST_DEV_ADDR: begin
                           if (shreg[7:1] == SLAVE_ADDR) begin
                              state  <= ST_ACK_DEV;
                              rw     <= shreg[0];
                              busy   <= 1'b1;
                              sda_oe <= ~ACK;
                           end else begin
                              state <= ST_IGNORE;
                              busy  <= 1'b0;
                           end
                        end
                        ST_ADDR_HI: begin
                           addr_hi <= shreg;
                           state   <= ST_ACK_HI;
                           sda_oe  <= ~ACK;
                        end
                        ST_ADDR_LO: begin
                           ptr    <= MEM_ADDR_BITS'({addr_hi, shreg});
                           state  <= ST_ACK_LO;
                           sda_oe <= ~ACK;
                        end
                        default: begin
                           wr_en   <= 1'b1;
                           wr_addr <= ptr;
                           wr_data <= shreg;
                           ptr     <= ptr + PTR_INC;
                           state   <= ST_ACK_WR;
                           sda_oe  <= ~ACK;
                        end
                     endcase
                  end
               end
               ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: begin
                  if (scl_fall) begin
                     bit_cnt <= '0;
                     sda_oe  <= 1'b0;
                     case (state)
                        ST_ACK_DEV: begin
                           if (rw) begin
                              state  <= ST_RD_DATA;
                              tx     <= rd_byte[6:0];
                              sda_oe <= ~rd_byte[7];
                           end else begin
                              state <= ST_ADDR_HI;
                           end
                        end
                        ST_ACK_HI: state <= ST_ADDR_LO;
                        default:   state <= ST_WR_DATA;
                     endcase
                  end
               end
               // MSB is put on the wire when entering RD_DATA; each later SCL fall shifts the next bit out
               ST_RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (byte_done) begin
                     state  <= ST_RD_ACK;
                     sda_oe <= 1'b0;
                     ptr    <= ptr + PTR_INC;
                  end else if (scl_fall) begin
                     sda_oe <= ~tx[6];
                     tx     <= {tx[5:0], 1'b0};
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda_s};
                  end else if (scl_fall) begin
                     if (shreg[0] == NACK) begin
                        state <= ST_IGNORE;
                     end else begin
                        state   <= ST_RD_DATA;
                        bit_cnt <= '0;
                        tx      <= rd_byte[6:0];
                        sda_oe  <= ~rd_byte[7];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb/tb_i2c_eeprom_slave.sv - bit-banged I2C master against a transaction-level EEPROM model
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
   localparam int Q = 60;
   localparam logic [7:0] DEV_W = 8'hA0;
   localparam logic [7:0] DEV_R = 8'hA1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int         total = 0;
   int         bad = 0;
   logic [7:0] m_mem [256];
   bit         m_valid [256];
   logic [7:0] m_ptr = 8'h00;
   logic [15:0] exp_q [$];
   logic [15:0] exp_e;
   logic [7:0] rd_q [$];
   bit         quiet = 1'b0;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_eeprom_slave dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scl_in  (scl),
      .sda_in  (sda_bus),
      .sda_oe  (sda_oe),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every committed write must match the next byte the model stored
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wr_unexpected: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
               exp_e = exp_q.pop_front();
               check("wr_event", {16'h0, wr_addr, wr_data}, {16'h0, exp_e});
            end
         end
         if (quiet) begin
            check("quiet_sda_oe", {31'h0, sda_oe}, 32'h0);
            check("quiet_busy", {31'h0, busy}, 32'h0);
         end
      end
   end

   task automatic clock_bit(input logic b, output logic s);
      sda_m = b; #Q;
      scl = 1'b1; #Q;
      s = sda_bus; #Q;
      scl = 1'b0; #Q;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q;
      scl = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q;
      scl = 1'b1; #Q;
      sda_m = 1'b1; #(2*Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         b[i] = s;
      end
      clock_bit(mack, s);
   endtask

   task automatic send_chk(input logic [7:0] b, input logic exp_ack, input string name);
      logic a;
      write_byte(b, a);
      check(name, {31'h0, a}, {31'h0, exp_ack});
   endtask

   task automatic set_ptr(input logic [7:0] hi, input logic [7:0] lo);
      i2c_start();
      send_chk(DEV_W, 1'b0, "ack_dev_w");
      send_chk(hi, 1'b0, "ack_addr_hi");
      send_chk(lo, 1'b0, "ack_addr_lo");
      m_ptr = 8'({hi, lo});
   endtask

   task automatic put_byte(input logic [7:0] d);
      exp_q.push_back({m_ptr, d});
      m_mem[m_ptr] = d;
      m_valid[m_ptr] = 1'b1;
      send_chk(d, 1'b0, "ack_data");
      m_ptr = m_ptr + 8'd1;
   endtask

   task automatic do_read(input int n);
      logic [7:0] b;
      i2c_start();
      send_chk(DEV_R, 1'b0, "ack_dev_r");
      rd_q.delete();
      for (int i = 0; i < n; i++) begin
         read_byte((i == n - 1) ? 1'b1 : 1'b0, b);
         rd_q.push_back(b);
         if (m_valid[m_ptr]) check("rd_data", {24'h0, b}, {24'h0, m_mem[m_ptr]});
         m_ptr = m_ptr + 8'd1;
      end
      i2c_stop();
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a;
      logic [7:0] b;
      logic [7:0] lo;
      int         n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_wr_en", {31'h0, wr_en}, 32'h0);
      check("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
      check("rst_wr_data", {24'h0, wr_data}, 32'h0);
      rst_n = 1'b1;
      #(4*Q);

      // Two-byte write at 0x05
      set_ptr(8'h00, 8'h05);
      check("busy_after_ack", {31'h0, busy}, 32'h1);
      put_byte(8'h3C);
      put_byte(8'hC3);
      i2c_stop();
      check("busy_after_stop", {31'h0, busy}, 32'h0);
      check("wr_pulses_035", exp_q.size(), 32'd0);
      check("model_ptr_035", {24'h0, m_ptr}, 32'h07);

      // Random read from 0x05
      set_ptr(8'h00, 8'h05);
      i2c_stop();
      do_read(2);
      check("rd036_0", {24'h0, rd_q[0]}, 32'h3C);
      check("rd036_1", {24'h0, rd_q[1]}, 32'hC3);

      // Foreign device address: slave stays off the bus
      quiet = 1'b1;
      i2c_start();
      send_chk(8'hA2, 1'b1, "nack_foreign_dev");
      send_chk(8'h00, 1'b1, "nack_foreign_b1");
      send_chk(8'h55, 1'b1, "nack_foreign_b2");
      i2c_stop();
      quiet = 1'b0;

      // Pointer wrap at the top of memory
      set_ptr(8'h3A, 8'hFF);
      put_byte(8'h11);
      put_byte(8'h22);
      i2c_stop();
      check("model_ptr_wrap", {24'h0, m_ptr}, 32'h01);
      set_ptr(8'h00, 8'hFF);
      i2c_stop();
      do_read(2);
      check("rd038_0", {24'h0, rd_q[0]}, 32'h11);
      check("rd038_1", {24'h0, rd_q[1]}, 32'h22);

      // STOP after only the high address byte leaves the pointer alone
      set_ptr(8'h00, 8'h05);
      i2c_stop();
      i2c_start();
      send_chk(DEV_W, 1'b0, "ack_dev_w");
      send_chk(8'h7E, 1'b0, "ack_addr_hi");
      i2c_stop();
      do_read(2);
      check("rd027_0", {24'h0, rd_q[0]}, 32'h3C);
      check("rd027_1", {24'h0, rd_q[1]}, 32'hC3);

      // Repeated START in the middle of a data byte
      set_ptr(8'h00, 8'h21);
      put_byte(8'h55);
      i2c_stop();
      set_ptr(8'h00, 8'h20);
      put_byte(8'hAA);
      clock_bit(1'b1, a);
      clock_bit(1'b0, a);
      clock_bit(1'b1, a);
      i2c_start();
      send_chk(DEV_R, 1'b0, "ack_dev_r");
      read_byte(1'b1, b);
      check("rd039_model", {24'h0, b}, {24'h0, m_mem[m_ptr]});
      check("rd039_lit", {24'h0, b}, 32'h55);
      m_ptr = m_ptr + 8'd1;
      i2c_stop();

      // Reset while the slave is driving a read bit low
      set_ptr(8'h00, 8'h21);
      i2c_stop();
      i2c_start();
      send_chk(DEV_R, 1'b0, "ack_dev_r");
      check("rd_drive_low", {31'h0, sda_oe}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("async_rst_sda_oe", {31'h0, sda_oe}, 32'h0);
      check("async_rst_busy", {31'h0, busy}, 32'h0);
      m_ptr = 8'h00;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #(2*Q);
      do_read(1);
      check("rd040_lit", {24'h0, rd_q[0]}, 32'h22);

      // Randomized write bursts followed by random-read setup and readback
      repeat (8) begin
         lo = 8'($urandom);
         n = $urandom_range(1, 4);
         set_ptr(8'($urandom), lo);
         for (int i = 0; i < n; i++) put_byte(8'($urandom));
         i2c_stop();
         set_ptr(8'($urandom), lo);
         i2c_stop();
         do_read(n);
      end

      #(4*Q);
      check("wr_queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
